// File: rtl/unpacker_8to12.sv
// unpacker_8to12: rebuilds 12-bit samples from the 3-bytes-per-2-samples
// stream made by packer_12to8 (byte0=A[11:4], byte1={A[3:0],B[11:8]}, byte2=B[7:0]).
// Latency: a sample is presented 1 cycle after its completing byte is accepted.
// Backpressure: single-entry output register; in_ready = !flush && (!out_valid || out_ready).
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   flush                synchronous realign to phase 0, drops partial group
//   in_valid/in_ready    byte handshake, in_data is the packed byte
//   out_valid/out_ready  sample handshake, out_data is the recovered sample
//   err, err_count       sawtooth mismatch pulse and saturating count
//
// Build option: define UNPACKER_SAWTOOTH_CHECK_EN to enable the sawtooth
// checker; otherwise err and err_count are tied to zero.

module unpacker_8to12 #(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [11:0]     out_data,
  input  logic            out_ready,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  phase_t      phase;
  phase_t      phase_next;

  logic [7:0]  hi;         // A[11:4] held from byte0
  logic [3:0]  nib;        // B[11:8] held from byte1

  logic        accept;
  logic        load;
  logic [11:0] load_data;
  logic        pop;

  // ---------------------------------------------------------------------------
  // Phase FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase <= PH0;
    end else begin
      phase <= phase_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase FSM: next state. Only an accepted byte advances the phase;
  // flush always realigns to the start of a group.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_next = phase;
    if (flush) begin
      phase_next = PH0;
    end else if (accept) begin
      unique case (phase)
        PH0:     phase_next = PH1;
        PH1:     phase_next = PH2;
        PH2:     phase_next = PH0;
        default: phase_next = PH0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Phase FSM: outputs / datapath controls.
  // in_ready is combinational from out_ready so a pop and a load can share a
  // cycle, giving one byte per cycle while the consumer keeps up.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = !flush && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    load      = 1'b0;
    load_data = 12'h000;
    unique case (phase)
      PH1: begin
        load      = accept;
        load_data = {hi, in_data[7:4]};
      end
      PH2: begin
        load      = accept;
        load_data = {nib, in_data};
      end
      default: begin
        load      = 1'b0;
        load_data = 12'h000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Partial-group holding registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hi  <= 8'h00;
      nib <= 4'h0;
    end else if (flush) begin
      hi  <= 8'h00;
      nib <= 4'h0;
    end else if (accept) begin
      if (phase == PH0) begin
        hi <= in_data;
      end
      if (phase == PH1) begin
        nib <= in_data[3:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Single-entry output register. A load wins over a pop in the same cycle,
  // so out_valid stays high and the new sample replaces the one just taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= 12'h000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

`ifdef UNPACKER_SAWTOOTH_CHECK_EN
  // ---------------------------------------------------------------------------
  // Sawtooth checker. Every loaded sample reseeds prev, so a single bad
  // sample costs one mismatch (plus the one following it if the stream then
  // resumes the original sequence), never a permanent error state.
  // ---------------------------------------------------------------------------
  localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

  logic [11:0] prev;
  logic        seeded;
  logic [11:0] prev_inc;
  logic        mismatch;

  assign prev_inc = prev + 12'd1;   // wraps 0xFFF -> 0x000
  assign mismatch = load && seeded && (load_data != prev_inc);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prev      <= 12'h000;
      seeded    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else if (flush) begin
      prev   <= 12'h000;
      seeded <= 1'b0;
      err    <= 1'b0;
    end else begin
      // err is registered so it lines up with the rising out_valid of the
      // offending sample.
      err <= mismatch;
      if (load) begin
        prev   <= load_data;
        seeded <= 1'b1;
      end
      if (mismatch && (err_count != ERR_MAX)) begin
        err_count <= err_count + ERR_ONE;
      end
    end
  end
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule
